// File: rtl/xor_join_stage.sv
// Joins two valid/ready streams, XORs each paired word and buffers the results
// in a small FIFO; also tracks completed output transfers and running parity.
module xor_join_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             c_valid,
  output logic [WIDTH-1:0] c_data,
  input  logic             c_ready,
  output logic [CNT_W-1:0] count,
  output logic             parity,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             parity_q, parity_d;

  logic             pop;
  logic             space;
  logic             push;
  logic [WIDTH-1:0] push_word;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign c_valid = (occ_q != '0);
  assign c_data  = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign parity  = parity_q;
  assign a_ready = b_valid && space;
  assign b_ready = a_valid && space;

  // A full FIFO still accepts a pair in the cycle its head is consumed.
  always_comb begin
    pop       = c_valid && c_ready;
    space     = !full || pop;
    push      = a_valid && b_valid && space;
    push_word = a_data ^ b_data;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    parity_d = parity_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      parity_d = parity_q ^ (^push_word);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      parity_q <= parity_d;
    end
  end

  // Storage is not reset; stale words are unreachable once occupancy clears.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

endmodule

// File: tb/tb_xor_join_stage.sv
// Directed bench for xor_join_stage: reset, pairing, backpressure, stall,
// mid-stream reset, streaming equivalence and counter wrap.
module tb_xor_join_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, c_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, c_valid, parity, full;
  logic [7:0] c_data, count;

  int n_vec = 0;
  int n_err = 0;

  xor_join_stage #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .count(count), .parity(parity), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  logic [7:0] ta [8] = '{8'h12, 8'hFF, 8'h00, 8'h5A, 8'h81, 8'h7E, 8'hC3, 8'h01};
  logic [7:0] tb [8] = '{8'h34, 8'h0F, 8'h00, 8'hA5, 8'h18, 8'h7F, 8'h3C, 8'h80};
  logic       p_model;
  logic [7:0] w;

  initial begin
    rst_n = 1'b0; c_ready = 1'b0; idle(); a_data = 8'h00; b_data = 8'h00;

    // T1: reset held two cycles with both sides valid
    pair(8'h11, 8'h22);
    tick(); tick();
    chk1("t1_c_valid", c_valid, 1'b0);
    chk8("t1_count", count, 8'h00);
    chk1("t1_parity", parity, 1'b0);
    chk1("t1_full", full, 1'b0);
    idle(); rst_n = 1'b1;
    tick();
    chk1("t1_no_push", c_valid, 1'b0);

    // T2: single pair
    c_ready = 1'b1; pair(8'hA5, 8'h0F); #1;
    chk1("t2_a_ready", a_ready, 1'b1);
    chk1("t2_b_ready", b_ready, 1'b1);
    tick(); idle(); #1;
    chk1("t2_c_valid", c_valid, 1'b1);
    chk8("t2_c_data", c_data, 8'hAA);
    chk8("t2_count0", count, 8'h00);
    tick();
    chk1("t2_drained", c_valid, 1'b0);
    chk8("t2_count1", count, 8'h01);
    chk1("t2_parity", parity, 1'b0);
    c_ready = 1'bx;
    tick();
    chk8("t2_x_ready_count", count, 8'h01);
    chk1("t2_x_ready_valid", c_valid, 1'b0);

    // T3: backpressure then drain; the 3rd pair enters as the head leaves
    c_ready = 1'b0;
    pair(8'h01, 8'h00); tick();
    pair(8'h02, 8'h00); #1;
    chk1("t3_a_ready2", a_ready, 1'b1);
    tick();
    pair(8'h03, 8'h00); #1;
    chk1("t3_full", full, 1'b1);
    chk1("t3_a_stall", a_ready, 1'b0);
    chk1("t3_b_stall", b_ready, 1'b0);
    chk8("t3_head", c_data, 8'h01);
    tick();
    chk1("t3_still_full", full, 1'b1);
    chk8("t3_head_stable", c_data, 8'h01);
    chk1("t3_parity", parity, 1'b0);
    c_ready = 1'b1; #1;
    chk1("t3_a_ready_pop", a_ready, 1'b1);
    tick(); idle(); #1;
    chk1("t3_full_kept", full, 1'b1);
    chk8("t3_d02", c_data, 8'h02);
    chk8("t3_count2", count, 8'h02);
    tick();
    chk8("t3_d03", c_data, 8'h03);
    chk1("t3_not_full", full, 1'b0);
    chk8("t3_count3", count, 8'h03);
    tick();
    chk1("t3_empty", c_valid, 1'b0);
    chk8("t3_count4", count, 8'h04);
    chk1("t3_parity_end", parity, 1'b0);

    // T4: full FIFO with simultaneous pop and push
    c_ready = 1'b0;
    pair(8'h10, 8'h03); tick();
    pair(8'h20, 8'h02); tick();
    chk1("t4_full", full, 1'b1);
    c_ready = 1'b1; pair(8'h40, 8'h04); #1;
    chk1("t4_a_ready", a_ready, 1'b1);
    chk1("t4_b_ready", b_ready, 1'b1);
    chk8("t4_head", c_data, 8'h13);
    tick(); idle(); #1;
    chk1("t4_full_kept", full, 1'b1);
    chk8("t4_d22", c_data, 8'h22);
    chk8("t4_count5", count, 8'h05);
    tick();
    chk8("t4_d44", c_data, 8'h44);
    tick();
    chk1("t4_empty", c_valid, 1'b0);
    chk8("t4_count7", count, 8'h07);
    chk1("t4_parity", parity, 1'b1);

    // T5: lone A valid stalls until B arrives
    a_data = 8'h5A; a_valid = 1'b1; b_data = 8'hFF; b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("t5_a_stall", a_ready, 1'b0);
      chk1("t5_no_out", c_valid, 1'b0);
      tick();
    end
    b_data = 8'h3C; b_valid = 1'b1; #1;
    chk1("t5_a_ready", a_ready, 1'b1);
    tick(); idle(); #1;
    chk1("t5_c_valid", c_valid, 1'b1);
    chk8("t5_c_data", c_data, 8'h66);
    tick();
    chk1("t5_one_word", c_valid, 1'b0);
    chk8("t5_count8", count, 8'h08);
    chk1("t5_parity", parity, 1'b1);

    // T6: mid-stream reset discards queued entries
    c_ready = 1'b0;
    pair(8'h01, 8'h00); tick();
    pair(8'h02, 8'h00); tick();
    chk1("t6_full", full, 1'b1);
    idle(); rst_n = 1'b0; tick();
    rst_n = 1'b1; #1;
    chk1("t6_c_valid", c_valid, 1'b0);
    chk1("t6_full_clr", full, 1'b0);
    chk8("t6_count", count, 8'h00);
    chk1("t6_parity", parity, 1'b0);
    pair(8'h81, 8'h00); tick(); idle(); #1;
    chk8("t6_first", c_data, 8'h81);
    tick();
    chk1("t6_alone_valid", c_valid, 1'b1);
    chk8("t6_alone_stable", c_data, 8'h81);
    c_ready = 1'b1; tick();
    chk1("t6_drained", c_valid, 1'b0);
    chk8("t6_count1", count, 8'h01);

    // Streaming equivalence: c_data is a^b delayed one cycle
    p_model = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pair(ta[i], tb[i]);
      tick();
      w = ta[i] ^ tb[i];
      p_model = p_model ^ (^w);
      chk1("eq_valid", c_valid, 1'b1);
      chk8("eq_data", c_data, w);
    end
    idle(); tick();
    chk8("eq_count9", count, 8'h09);
    chk1("eq_parity", parity, p_model);

    // Counter wrap: 247 more transfers take 9 to 256 == 0
    for (int i = 0; i < 247; i++) begin
      pair(8'(i), 8'h55);
      tick();
    end
    idle(); tick();
    chk1("wrap_empty", c_valid, 1'b0);
    chk8("wrap_count", count, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
